mem_port_arbiter: RTL and testbench

- Shares the single-port unified data/instruction memory between two requesters: the instruction-fetch unit (I-port) and the load/store unit (D-port).
- The memory has a combinational read, a synchronous write and word indexing by address/4.
- The block sequences each access through a small FSM, arbitrates round-robin, registers read data back to the winner, and flags misaligned or out-of-range addresses without touching memory.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, owner encodings and the address legality check for the
// instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Word index is passed pre-shifted so one helper serves any address width.
    function automatic logic addr_err(input logic [1:0]  byte_off,
                                      input logic [63:0] word_idx,
                                      input int unsigned mem_words);
        return (byte_off != 2'b00) || (word_idx >= 64'(mem_words));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and memory-side signals of the shared memory
// arbiter; slave is the arbiter's view, master the requesters' and memory's.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_A;
    logic [DATA_W-1:0] mem_WD;
    logic              mem_WE;
    logic [DATA_W-1:0] mem_RD;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_A, mem_WD, mem_WE
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_A, mem_WD, mem_WE
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins;
// a lone requester is granted at once.
module rr_arbiter_2
    import mem_arb_pkg::*;
#(
    parameter bit FETCH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (&req) begin
                gnt[~last_q] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset pretends the other port went last so the preferred port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= FETCH_FIRST ? OWN_D : OWN_I;
        end else if (|gnt) begin
            last_q <= gnt[OWN_D];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch unit and the load/store
// unit: round-robin grant, one access per two cycles, registered responses.
//
//   state  | meaning
//   IDLE   | no access in flight, requests may be granted
//   ACCESS | latched request drives the memory, read data captured
//   RESP   | owner's rvalid pulses, next request may be granted
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MEM_WORDS   = 32,
    parameter bit FETCH_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [1:0]        req, gnt;
    logic              arb_en;
    logic              accept;

    logic              sel_owner;
    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_val;

    logic              owner_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign req[OWN_I] = bus.i_req;
    assign req[OWN_D] = bus.d_req;
    // rst_n gates the grant so no request is acknowledged while held in reset.
    assign arb_en     = rst_n && (state_q != ACCESS);

    rr_arbiter_2 #(
        .FETCH_FIRST (FETCH_FIRST)
    ) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .enable (arb_en),
        .gnt    (gnt)
    );

    always_comb begin
        sel_owner = gnt[OWN_D];
        sel_addr  = sel_owner ? bus.d_addr : bus.i_addr;
        sel_we    = sel_owner & bus.d_we;
        sel_wdata = sel_owner ? bus.d_wdata : '0;
        sel_err   = addr_err(sel_addr[1:0], 64'(sel_addr >> 2), MEM_WORDS);
        rd_val    = (we_q || err_q) ? '0 : bus.mem_RD;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                accept  = |gnt;
                state_d = accept ? ACCESS : IDLE;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= sel_owner;
                we_q    <= sel_we;
                err_q   <= sel_err;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= rd_val;
                end else begin
                    i_rdata_q <= rd_val;
                end
            end
        end
    end

    // err_q stays valid through RESP: a new acceptance only reloads it at RESP's closing edge.
    assign bus.i_gnt    = gnt[OWN_I];
    assign bus.d_gnt    = gnt[OWN_D];
    assign bus.i_rvalid = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.d_rvalid = (state_q == RESP) && (owner_q == OWN_D);
    assign bus.i_err    = bus.i_rvalid && err_q;
    assign bus.d_err    = bus.d_rvalid && err_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    assign bus.mem_A    = addr_q;
    assign bus.mem_WD   = wdata_q;
    assign bus.mem_WE   = (state_q == ACCESS) && we_q && !err_q && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, with a
// transaction-level reference model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WORDS = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_WORDS   (WORDS),
        .FETCH_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit preload_done = 1'b0;

    function automatic logic [31:0] init_word(input int k);
        if (k == 1) return 32'h0040_0313;
        return 32'h1000_0000 + 32'(k * 32'h11);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory environment: combinational read, write on the clock edge.
    logic [DW-1:0] mem [WORDS];
    assign bus.mem_RD = (bus.mem_A[AW-1:2] < 30'(WORDS)) ? mem[bus.mem_A[6:2]] : '0;

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int k = 0; k < WORDS; k++) mem[k] <= init_word(k);
        end else if (bus.mem_WE && (bus.mem_A[AW-1:2] < 30'(WORDS))) begin
            mem[bus.mem_A[6:2]] <= bus.mem_WD;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and compare ----------------
    typedef struct {
        int          acc;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rec_t        inflight[$];
    logic [31:0] ref_mem [WORDS];
    bit          m_last_d;
    bit          m_busy;
    logic [31:0] m_addr_hold, m_i_data, m_d_data;

    int   ig_log[$];
    int   dg_log[$];
    int   we_log[$];
    rsp_t rsp_log[$];
    bit   i_took, d_took;

    always @(negedge clk) begin : cmp
        bit eg_i, eg_d, ev_i, ev_d, e_we, e_err;
        logic [31:0] e_data, e_wd, a;
        rec_t r;

        if (bus.i_gnt === 1'b1) ig_log.push_back(cyc);
        if (bus.d_gnt === 1'b1) dg_log.push_back(cyc);
        if (bus.mem_WE === 1'b1) we_log.push_back(cyc);
        if (bus.i_rvalid === 1'b1) rsp_log.push_back('{cyc, 1'b0, bus.i_rdata, bus.i_err});
        if (bus.d_rvalid === 1'b1) rsp_log.push_back('{cyc, 1'b1, bus.d_rdata, bus.d_err});
        i_took = bus.i_gnt;
        d_took = bus.d_gnt;

        if (!rst_n) begin
            if (!preload_done) begin
                for (int k = 0; k < WORDS; k++) ref_mem[k] = init_word(k);
            end
            inflight.delete();
            m_last_d    = 1'b1;
            m_busy      = 1'b0;
            m_addr_hold = '0;
            m_i_data    = '0;
            m_d_data    = '0;
            chk("rst_ctrl", 32'({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
                                 bus.i_err, bus.d_err, bus.mem_WE}), 32'd0);
            chk("rst_mem_A", bus.mem_A, 32'd0);
            chk("rst_mem_WD", bus.mem_WD, 32'd0);
            chk("rst_i_rdata", bus.i_rdata, 32'd0);
            chk("rst_d_rdata", bus.d_rdata, 32'd0);
        end else begin
            eg_i = 1'b0;
            eg_d = 1'b0;
            if (!m_busy) begin
                if (bus.i_req && bus.d_req) begin
                    eg_i = m_last_d;
                    eg_d = !m_last_d;
                end else begin
                    eg_i = bus.i_req;
                    eg_d = bus.d_req;
                end
            end

            e_we = 1'b0; ev_i = 1'b0; ev_d = 1'b0; e_err = 1'b0;
            e_data = '0; e_wd = '0;
            foreach (inflight[k]) begin
                if (inflight[k].acc + 1 == cyc) begin
                    m_addr_hold = inflight[k].addr;
                    inflight[k].data = '0;
                    if (!inflight[k].err) begin
                        if (inflight[k].we) begin
                            e_we = 1'b1;
                            e_wd = inflight[k].wdata;
                            ref_mem[inflight[k].addr / 4] = inflight[k].wdata;
                        end else begin
                            inflight[k].data = ref_mem[inflight[k].addr / 4];
                        end
                    end
                end
                if (inflight[k].acc + 2 == cyc) begin
                    e_err  = inflight[k].err;
                    e_data = inflight[k].data;
                    if (inflight[k].port) begin
                        ev_d = 1'b1;
                        m_d_data = e_data;
                    end else begin
                        ev_i = 1'b1;
                        m_i_data = e_data;
                    end
                end
            end

            chk("i_gnt", 32'(bus.i_gnt), 32'(eg_i));
            chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
            chk("mem_WE", 32'(bus.mem_WE), 32'(e_we));
            chk("mem_A", bus.mem_A, m_addr_hold);
            if (e_we) chk("mem_WD", bus.mem_WD, e_wd);
            chk("i_rvalid", 32'(bus.i_rvalid), 32'(ev_i));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(ev_d));
            chk("i_err", 32'(bus.i_err), 32'(ev_i && e_err));
            chk("d_err", 32'(bus.d_err), 32'(ev_d && e_err));
            chk("i_rdata", bus.i_rdata, m_i_data);
            chk("d_rdata", bus.d_rdata, m_d_data);

            if (eg_i || eg_d) begin
                a = eg_d ? bus.d_addr : bus.i_addr;
                r.acc   = cyc;
                r.port  = eg_d;
                r.we    = eg_d && bus.d_we;
                r.addr  = a;
                r.wdata = bus.d_wdata;
                r.err   = (a % 4 != 0) || (a / 4 >= WORDS);
                r.data  = '0;
                inflight.push_back(r);
                m_last_d = eg_d;
            end
            m_busy = eg_i || eg_d;
            while (inflight.size() > 0 && inflight[0].acc + 2 <= cyc) void'(inflight.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit port);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((port ? bus.d_gnt : bus.i_gnt) === 1'b1) break;
            n++;
            if (n > 20) begin
                n_checks++;
                n_errors++;
                $display("FAIL gnt_timeout: port %0d not granted within 20 cycles", port);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        wait_gnt(1'b0);
        bus.i_req  = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        wait_gnt(1'b1);
        bus.d_req   = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
            1:       return 32'(WORDS * 4 + $urandom_range(0, 200) * 4);
            default: return 32'($urandom_range(0, WORDS - 1) * 4);
        endcase
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int mi, md, mw, mr, t;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 preload_done = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // single fetch of word 1
        mi = ig_log.size(); mr = rsp_log.size();
        do_fetch(32'd4);
        chk("fetch_mem_A_T1", bus.mem_A, 32'd4);
        repeat (3) tick();
        t = ig_log[mi];
        chk("fetch_gnt_count", 32'(ig_log.size() - mi), 32'd1);
        chk("fetch_rsp_cycle", 32'(rsp_log[mr].cyc - t), 32'd2);
        chk("fetch_rdata", rsp_log[mr].data, 32'h0040_0313);
        chk("fetch_err", 32'(rsp_log[mr].err), 32'd0);

        // back-to-back loads at 0, 4, 8
        md = dg_log.size(); mr = rsp_log.size();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd0;
        wait_gnt(1'b1);
        bus.d_addr = 32'd4;
        wait_gnt(1'b1);
        bus.d_addr = 32'd8;
        wait_gnt(1'b1);
        bus.d_req = 1'b0;
        repeat (3) tick();
        chk("b2b_gnt_gap1", 32'(dg_log[md + 1] - dg_log[md]), 32'd2);
        chk("b2b_gnt_gap2", 32'(dg_log[md + 2] - dg_log[md + 1]), 32'd2);
        chk("b2b_rsp0_cycle", 32'(rsp_log[mr].cyc - dg_log[md]), 32'd2);
        chk("b2b_rsp0", rsp_log[mr].data, 32'h1000_0000);
        chk("b2b_rsp1", rsp_log[mr + 1].data, 32'h0040_0313);
        chk("b2b_rsp2", rsp_log[mr + 2].data, 32'h1000_0022);

        // store then load at 8
        md = dg_log.size(); mw = we_log.size(); mr = rsp_log.size();
        do_data(1'b1, 32'd8, 32'hDEAD_BEEF);
        chk("store_WE_in_access", 32'(bus.mem_WE), 32'd1);
        repeat (2) tick();
        do_data(1'b0, 32'd8, 32'd0);
        repeat (3) tick();
        chk("store_we_count", 32'(we_log.size() - mw), 32'd1);
        chk("store_we_cycle", 32'(we_log[mw] - dg_log[md]), 32'd1);
        chk("store_ack_rdata", rsp_log[mr].data, 32'd0);
        chk("load_after_store", rsp_log[mr + 1].data, 32'hDEAD_BEEF);

        // misaligned store and out-of-range fetch
        mw = we_log.size(); mr = rsp_log.size();
        do_data(1'b1, 32'd6, 32'h1234_5678);
        repeat (2) tick();
        do_fetch(32'd128);
        repeat (3) tick();
        chk("err_store_no_we", 32'(we_log.size() - mw), 32'd0);
        chk("err_store_derr", 32'(rsp_log[mr].err), 32'd1);
        chk("err_word1_kept", mem[1], 32'h0040_0313);
        chk("err_fetch_ierr", 32'(rsp_log[mr + 1].err), 32'd1);
        chk("err_fetch_rdata", rsp_log[mr + 1].data, 32'd0);

        // contention straight after reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        mi = ig_log.size(); md = dg_log.size(); mr = rsp_log.size();
        bus.i_req = 1'b1; bus.i_addr = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd4;
        repeat (7) tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) tick();
        chk("cont_i_then_d", 32'(dg_log[md] - ig_log[mi]), 32'd2);
        chk("cont_d_then_i", 32'(ig_log[mi + 1] - dg_log[md]), 32'd2);
        chk("cont_i_then_d2", 32'(dg_log[md + 1] - ig_log[mi + 1]), 32'd2);
        chk("cont_rsp_order", 32'({rsp_log[mr].port, rsp_log[mr + 1].port,
                                   rsp_log[mr + 2].port, rsp_log[mr + 3].port}), 32'b0101);

        // reset during the access cycle of a store
        do_data(1'b1, 32'd12, 32'hCAFE_F00D);
        chk("rst_store_WE_before", 32'(bus.mem_WE), 32'd1);
        mr = rsp_log.size(); mw = we_log.size();
        rst_n = 1'b0;
        #1;
        chk("rst_store_WE_drop", 32'(bus.mem_WE), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_word3_kept", mem[3], init_word(3));
        chk("rst_no_rvalid", 32'(rsp_log.size() - mr), 32'd0);
        chk("rst_no_write", 32'(we_log.size() - mw), 32'd0);
        mi = ig_log.size();
        do_fetch(32'd16);
        repeat (3) tick();
        chk("post_rst_latency", 32'(rsp_log[mr].cyc - ig_log[mi]), 32'd2);
        chk("post_rst_rdata", rsp_log[mr].data, init_word(4));

        // random traffic
        for (int c = 0; c < 800; c++) begin
            if (!bus.i_req || i_took) begin
                bus.i_req  = ($urandom_range(0, 3) != 0);
                bus.i_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_addr = rand_addr();
            end
            if (!bus.d_req || d_took) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom();
            end else if ($urandom_range(0, 15) == 0) begin
                bus.d_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.d_wdata = $urandom();
            end
            tick();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
